// File: rtl/silife_grid_reader.sv
// Snapshot reader for the silife cell array: captures the grid on start and streams it row by row.
// Optional SILIFE_READER_POPCOUNT_EN adds a per-frame live-cell count on `population`.
module silife_grid_reader #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned HEIGHT = 8,
   localparam int unsigned ROW_BITS = $clog2(HEIGHT)
`ifdef SILIFE_READER_POPCOUNT_EN
   ,
   localparam int unsigned POP_BITS = $clog2(WIDTH*HEIGHT+1)
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [WIDTH*HEIGHT-1:0] cells,
   input  logic                    start,
   output logic                    busy,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ROW_BITS-1:0]     out_row,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_last,
   output logic                    frame_done
`ifdef SILIFE_READER_POPCOUNT_EN
   ,
   output logic [POP_BITS-1:0]     population
`endif
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(HEIGHT-1);

   state_t                  state_q, state_d;
   logic [WIDTH*HEIGHT-1:0] snap_q, snap_d;
   logic                    busy_d, valid_d, last_d, done_d;
   logic [ROW_BITS-1:0]     row_d;
   logic [WIDTH-1:0]        data_d;
   logic                    xfer;

`ifdef SILIFE_READER_POPCOUNT_EN
   logic [POP_BITS-1:0] acc_q, acc_d, pop_d, pop_sum;

   function automatic logic [POP_BITS-1:0] row_pop(input logic [WIDTH-1:0] d);
      logic [POP_BITS-1:0] n;
      n = '0;
      for (int unsigned c = 0; c < WIDTH; c++) n = n + POP_BITS'(d[c]);
      return n;
   endfunction

   assign pop_sum = acc_q + row_pop(out_data);
`endif

   // Row multiplexer over a flattened row-major grid.
   function automatic logic [WIDTH-1:0] row_sel(input logic [WIDTH*HEIGHT-1:0] g,
                                                input logic [ROW_BITS-1:0]     sel);
      logic [WIDTH-1:0] res;
      res = '0;
      for (int unsigned r = 0; r < HEIGHT; r++)
         if (sel == ROW_BITS'(r)) res = g[r*WIDTH +: WIDTH];
      return res;
   endfunction

   assign xfer = out_valid && out_ready;

   // Next-state and next-output logic; out_row doubles as the row counter.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      busy_d  = busy;
      valid_d = out_valid;
      last_d  = out_last;
      done_d  = 1'b0;
      row_d   = out_row;
      data_d  = out_data;
`ifdef SILIFE_READER_POPCOUNT_EN
      acc_d   = acc_q;
      pop_d   = population;
`endif
      case (state_q)
         IDLE: begin
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            row_d   = '0;
            data_d  = '0;
            if (start) begin
               state_d = SEND;
               snap_d  = cells;
               busy_d  = 1'b1;
               valid_d = 1'b1;
               data_d  = row_sel(cells, '0);
`ifdef SILIFE_READER_POPCOUNT_EN
               acc_d   = '0;
`endif
            end
         end
         SEND: begin
            busy_d  = 1'b1;
            valid_d = 1'b1;
            if (xfer) begin
               if (out_row == LAST_ROW) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  row_d   = '0;
                  data_d  = '0;
`ifdef SILIFE_READER_POPCOUNT_EN
                  pop_d   = pop_sum;
`endif
               end else begin
                  row_d  = out_row + ROW_BITS'(1);
                  data_d = row_sel(snap_q, row_d);
                  last_d = (row_d == LAST_ROW);
`ifdef SILIFE_READER_POPCOUNT_EN
                  acc_d  = pop_sum;
`endif
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            row_d   = '0;
            data_d  = '0;
         end
      endcase
   end

   // State, snapshot and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         snap_q     <= '0;
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         out_row    <= '0;
         out_data   <= '0;
`ifdef SILIFE_READER_POPCOUNT_EN
         acc_q      <= '0;
         population <= '0;
`endif
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         busy       <= busy_d;
         out_valid  <= valid_d;
         out_last   <= last_d;
         frame_done <= done_d;
         out_row    <= row_d;
         out_data   <= data_d;
`ifdef SILIFE_READER_POPCOUNT_EN
         acc_q      <= acc_d;
         population <= pop_d;
`endif
      end
   end

endmodule

// File: tb/tb_silife_grid_reader.sv
// Randomized and directed bench for silife_grid_reader against a queue-based frame model.
module tb_silife_grid_reader;
   localparam int W = 8;
   localparam int H = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           out_ready = 1'b0;
   logic [W*H-1:0] cells = '0;
   logic           busy, out_valid, out_last, frame_done;
   logic [2:0]     out_row;
   logic [W-1:0]   out_data;
`ifdef SILIFE_READER_POPCOUNT_EN
   logic [6:0]     population;
`endif

   silife_grid_reader #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .cells(cells), .start(start), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_data(out_data), .out_last(out_last), .frame_done(frame_done)
`ifdef SILIFE_READER_POPCOUNT_EN
      , .population(population)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is the queue of rows still to be delivered; one DONE cycle follows the last.
   logic [W-1:0] q[$];
   bit           m_done = 0;
   int           m_pop = 0;
   int           m_frame_pop = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_done = 0;
         m_pop  = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (q.size() != 0) begin
         if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
               m_done = 1;
               m_pop  = m_frame_pop;
            end
         end
      end else if (start) begin
         m_frame_pop = 0;
         for (int r = 0; r < H; r++) begin
            q.push_back(cells[r*W +: W]);
            m_frame_pop += $countones(cells[r*W +: W]);
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      chk("busy", busy, (q.size() != 0) || m_done);
      chk("out_valid", out_valid, q.size() != 0);
      chk("frame_done", frame_done, m_done);
      if (q.size() != 0) begin
         chk("out_row", out_row, H - q.size());
         chk("out_data", out_data, q[0]);
         chk("out_last", out_last, q.size() == 1);
      end
`ifdef SILIFE_READER_POPCOUNT_EN
      if (q.size() == 0) chk("population", population, m_pop);
`endif
   end

   // Accepted beats, for end-of-frame literal checks.
   logic [W-1:0] acc_q[$];
   always @(posedge clk)
      if (rst_n && out_valid && out_ready) acc_q.push_back(out_data);

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         step();
         k++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   task automatic load_diag();
      for (int r = 0; r < H; r++) cells[r*W +: W] = 8'h01 << r;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   logic [W*H-1:0] saved;
   logic [W-1:0]   exp_row;
   int             busy_cnt;
   int             k;

   initial begin
      step(2);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_row", out_row, 0);
      chk("rst_done", frame_done, 0);
      rst_n = 1'b1;
      step();

      // Streaming frame with out_ready held high.
      load_diag();
      out_ready = 1'b1;
      acc_q.delete();
      pulse_start();
      busy_cnt = 0;
      for (int c = 1; c <= 11; c++) begin
         busy_cnt += int'(busy);
         if (c <= 8) begin
            exp_row = 8'h01 << (c - 1);
            chk("stream_row", out_row, c - 1);
            chk("stream_data", out_data, exp_row);
            chk("stream_last", out_last, c == 8);
         end
         chk("stream_done", frame_done, c == 9);
         step();
      end
      chk("stream_busy_cycles", busy_cnt, 9);
      chk("stream_beats", acc_q.size(), 8);

      // Backpressure 1,0,0,1,0,0...
      acc_q.delete();
      out_ready = 1'b1;
      pulse_start();
      k = 1;
      while (busy && k < 80) begin
         out_ready = (k % 3 == 0);
         step();
         k++;
      end
      chk("bp_idle", busy, 0);
      chk("bp_beats", acc_q.size(), 8);
      for (int i = 0; i < 8 && i < acc_q.size(); i++) begin
         exp_row = 8'h01 << i;
         chk("bp_row", acc_q[i], exp_row);
      end

      // Snapshot isolation.
      acc_q.delete();
      cells = {$urandom, $urandom};
      saved = cells;
      out_ready = 1'b1;
      pulse_start();
      cells = '0;
      wait_idle(40);
      chk("iso_beats", acc_q.size(), 8);
      for (int i = 0; i < 8 && i < acc_q.size(); i++)
         chk("iso_row", acc_q[i], saved[i*W +: W]);

      // start during row 3 and during DONE must be ignored.
      acc_q.delete();
      load_diag();
      pulse_start();
      k = 0;
      while (!frame_done && k < 40) begin
         if (out_row == 3 && out_valid) start = 1'b1;
         step();
         start = 1'b0;
         k++;
      end
      chk("ign_done_seen", frame_done, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      step(3);
      chk("ign_idle_busy", busy, 0);
      chk("ign_idle_valid", out_valid, 0);
      chk("ign_beats", acc_q.size(), 8);

      // Reset mid-frame.
      cells = '1;
      pulse_start();
      step(3);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_data", out_data, 0);
      step(2);
      chk("midrst_nodone", frame_done, 0);
      rst_n = 1'b1;
      step();

`ifdef SILIFE_READER_POPCOUNT_EN
      cells = '0;
      cells[10] = 1'b1; cells[19] = 1'b1;
      cells[25] = 1'b1; cells[26] = 1'b1; cells[27] = 1'b1;
      out_ready = 1'b1;
      pulse_start();
      k = 0;
      while (!frame_done && k < 40) begin step(); k++; end
      chk("glider_done", frame_done, 1);
      chk("glider_pop", population, 5);
      step(2);
      cells = '1;
      pulse_start();
      k = 0;
      while (!frame_done && k < 40) begin step(); k++; end
      chk("ones_done", frame_done, 1);
      chk("ones_pop", population, 64);
      step(2);
`endif

      // Random traffic, including occasional resets.
      for (int i = 0; i < 600; i++) begin
         cells     = {$urandom, $urandom};
         start     = ($urandom_range(0, 3) == 0);
         out_ready = $urandom_range(0, 1);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
         end
         step();
      end
      start = 1'b0;
      out_ready = 1'b1;
      step(20);
      chk("final_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
